// File: rtl/mme_seq_ctrl_pkg.sv
// Shared types and constants for the MME 4x4 matrix-engine sequencer.
package mme_pkg;
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_A    = 4'd1,
        RD_B    = 4'd2,
        WAIT_RD = 4'd3,
        STEP    = 4'd4,
        DRAIN   = 4'd5,
        WR      = 4'd6,
        WAIT_WR = 4'd7,
        DONE    = 4'd8
    } mme_state_t;

    localparam int MME_COL_BYTES = 16;
    localparam int MME_C_BYTES   = 64;
    localparam int MME_COL_SHIFT = $clog2(MME_COL_BYTES);
endpackage

// File: rtl/mme_seq_ctrl_if.sv
// Config/status, DMA command/response and PE control signals of the MME sequencer.
interface mme_seq_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  mat_width;
    logic [ADDR_W-1:0] mat_a_addr;
    logic [ADDR_W-1:0] mat_b_addr;
    logic [ADDR_W-1:0] mat_c_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic              rd_cmd_sel;
    logic              rd_done;
    logic              rd_err;
    logic              pe_clear;
    logic              pe_step;
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [ADDR_W-1:0] wr_cmd_addr;
    logic              wr_done;
    logic              wr_err;

    modport master (
        input  start, mat_width, mat_a_addr, mat_b_addr, mat_c_addr,
               rd_cmd_ready, rd_done, rd_err, wr_cmd_ready, wr_done, wr_err,
        output busy, done, err, rd_cmd_valid, rd_cmd_addr, rd_cmd_sel,
               pe_clear, pe_step, wr_cmd_valid, wr_cmd_addr
    );

    modport slave (
        output start, mat_width, mat_a_addr, mat_b_addr, mat_c_addr,
               rd_cmd_ready, rd_done, rd_err, wr_cmd_ready, wr_done, wr_err,
        input  busy, done, err, rd_cmd_valid, rd_cmd_addr, rd_cmd_sel,
               pe_clear, pe_step, wr_cmd_valid, wr_cmd_addr
    );
endinterface

// File: rtl/mme_seq_ctrl_cnt.sv
// Loadable down-counter that saturates at zero; times the PE drain window.
module mme_seq_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mme_seq_ctrl.sv
// Job sequencer for the MME 4x4 engine: per-k A/B fetch, PE step, drain, C write-back.
module mme_seq_ctrl
    import mme_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 8,
    parameter int DRAIN_LAT = 7
) (
    input  logic           clk,
    input  logic           rst,
    mme_seq_ctrl_if.master bus
);
    mme_state_t        state;
    mme_state_t        state_nxt;
    logic [CNT_W-1:0]  w_reg;
    logic [CNT_W-1:0]  k;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] c_base;
    logic [1:0]        rd_cnt;
    logic [1:0]        rd_sum;
    logic              done_r;
    logic              err_r;
    logic              pe_clear_r;
    logic              accept;
    logic              reading;
    logic              rd_bad;
    logic              last_k;
    logic [CNT_W-1:0]  drain_cnt;
    logic              drain_zero;

    function automatic logic [ADDR_W-1:0] col_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  idx);
        logic [ADDR_W-1:0] off;
        off = ADDR_W'(idx) << MME_COL_SHIFT;
        return base + off;
    endfunction

    assign accept  = (state == IDLE) && bus.start;
    assign reading = (state == RD_A) || (state == RD_B) || (state == WAIT_RD);
    assign rd_sum  = rd_cnt + {1'b0, bus.rd_done};
    assign rd_bad  = reading && bus.rd_done && bus.rd_err;
    assign last_k  = (k == w_reg - CNT_W'(1));

    mme_seq_cnt #(.CNT_W(CNT_W)) u_drain (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == STEP) && last_k),
        .load_val (CNT_W'(DRAIN_LAT - 1)),
        .dec      (state == DRAIN),
        .cnt      (drain_cnt),
        .zero     (drain_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.mat_width == '0) ? DONE : RD_A;
            RD_A:    if (bus.rd_cmd_ready) state_nxt = RD_B;
            RD_B:    if (bus.rd_cmd_ready) state_nxt = WAIT_RD;
            // A bus error still lets both bursts land before the job is abandoned.
            WAIT_RD: if (rd_sum == 2'd2) state_nxt = (err_r || rd_bad) ? DONE : STEP;
            STEP:    state_nxt = last_k ? DRAIN : RD_A;
            DRAIN:   if (drain_zero) state_nxt = WR;
            WR:      if (bus.wr_cmd_ready) state_nxt = WAIT_WR;
            WAIT_WR: if (bus.wr_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            rd_cnt     <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            pe_clear_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            pe_clear_r <= accept;
            if (accept) begin
                done_r <= 1'b0;
                err_r  <= (bus.mat_width == '0);
                k      <= '0;
                rd_cnt <= '0;
            end
            if (state == STEP) begin
                k      <= k + CNT_W'(1);
                rd_cnt <= '0;
            end else if (reading && bus.rd_done) begin
                rd_cnt <= rd_sum;
            end
            if (rd_bad || ((state == WAIT_WR) && bus.wr_done && bus.wr_err)) err_r <= 1'b1;
            if (state_nxt == DONE && state != DONE) done_r <= 1'b1;
        end
    end

    // Shadow copies of the job config; only meaningful while a job runs.
    always_ff @(posedge clk) begin
        if (accept) begin
            w_reg  <= bus.mat_width;
            a_base <= bus.mat_a_addr;
            b_base <= bus.mat_b_addr;
            c_base <= bus.mat_c_addr;
        end
    end

    assign bus.busy         = (state != IDLE) && (state != DONE);
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.pe_clear     = pe_clear_r;
    assign bus.pe_step      = (state == STEP);
    assign bus.rd_cmd_valid = (state == RD_A) || (state == RD_B);
    assign bus.rd_cmd_sel   = (state == RD_B);
    assign bus.rd_cmd_addr  = (state == RD_A) ? col_addr(a_base, k) :
                              (state == RD_B) ? col_addr(b_base, k) : '0;
    assign bus.wr_cmd_valid = (state == WR);
    assign bus.wr_cmd_addr  = (state == WR) ? c_base : '0;
endmodule

// File: tb/tb_mme_seq_ctrl.sv
// Directed bench for mme_seq_ctrl with a small DMA responder and handshake monitor.
module tb_mme_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mme_seq_ctrl_if bus ();

    mme_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_rd_hs, n_wr_hs, n_wr_vld, n_pe_step, n_pe_clear, n_rd_done, stall_bad;
    logic [31:0] rd_addr_q[$];
    logic        rd_sel_q[$];
    logic [31:0] wr_addr_last = '0;
    logic [1:0]  rd_pipe = '0;
    logic [1:0]  wr_pipe = '0;
    logic        rd_stall_p = 1'b0;
    logic        wr_stall_p = 1'b0;
    logic [31:0] rd_addr_p = '0;
    logic [31:0] wr_addr_p = '0;
    logic        rd_sel_p = 1'b0;
    int          err_idx = 0;
    bit          stall_en = 1'b0;
    bit          wr_err_en = 1'b0;
    int          cyc_n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // DMA responder: rd_done/wr_done two cycles after each accepted command.
    always @(posedge clk) begin
        if (rst) begin
            n_rd_hs = 0; n_wr_hs = 0; n_wr_vld = 0; n_pe_step = 0;
            n_pe_clear = 0; n_rd_done = 0; stall_bad = 0;
            rd_addr_q.delete(); rd_sel_q.delete();
            rd_pipe = '0; wr_pipe = '0; rd_stall_p = 1'b0; wr_stall_p = 1'b0;
        end else begin
            if (rd_stall_p && (!bus.rd_cmd_valid || bus.rd_cmd_addr !== rd_addr_p ||
                               bus.rd_cmd_sel !== rd_sel_p)) stall_bad++;
            if (wr_stall_p && (!bus.wr_cmd_valid || bus.wr_cmd_addr !== wr_addr_p)) stall_bad++;
            rd_stall_p = bus.rd_cmd_valid && !bus.rd_cmd_ready;
            rd_addr_p  = bus.rd_cmd_addr;
            rd_sel_p   = bus.rd_cmd_sel;
            wr_stall_p = bus.wr_cmd_valid && !bus.wr_cmd_ready;
            wr_addr_p  = bus.wr_cmd_addr;
            if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
                n_rd_hs++;
                rd_addr_q.push_back(bus.rd_cmd_addr);
                rd_sel_q.push_back(bus.rd_cmd_sel);
            end
            if (bus.wr_cmd_valid) n_wr_vld++;
            if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
                n_wr_hs++;
                wr_addr_last = bus.wr_cmd_addr;
            end
            if (bus.pe_step) n_pe_step++;
            if (bus.pe_clear) n_pe_clear++;
            rd_pipe = {rd_pipe[0], bus.rd_cmd_valid && bus.rd_cmd_ready};
            wr_pipe = {wr_pipe[0], bus.wr_cmd_valid && bus.wr_cmd_ready};
        end
        #1;
        bus.rd_done = rd_pipe[1];
        if (rd_pipe[1]) n_rd_done++;
        bus.rd_err       = rd_pipe[1] && (n_rd_done == err_idx);
        bus.wr_done      = wr_pipe[1];
        bus.wr_err       = wr_pipe[1] && wr_err_en;
        bus.rd_cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.wr_cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] w, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
        bus.mat_width  = w;
        bus.mat_a_addr = a;
        bus.mat_b_addr = b;
        bus.mat_c_addr = c;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        int n = 1;
        while (!bus.done && n < budget) begin
            cyc();
            n++;
        end
        cycles = n;
        chk({tag, "_done"}, bus.done, 1);
    endtask

    task automatic wait_pe(input string tag, input int target);
        int n = 0;
        while (n_pe_step < target && n < 500) begin
            cyc();
            n++;
        end
        chk({tag, "_reach_k"}, n_pe_step, target);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        cfg(8'd0, 32'h0, 32'h0, 32'h0);
        do_reset();

        chk("rst_status", {bus.busy, bus.done, bus.err}, 3'b000);
        chk("rst_cmds", {bus.rd_cmd_valid, bus.rd_cmd_sel, bus.wr_cmd_valid,
                         bus.pe_clear, bus.pe_step}, 5'b00000);
        chk("rst_rd_addr", bus.rd_cmd_addr, 32'h0);

        // W=4 zero-wait job
        cfg(8'd4, 32'h0, 32'h1000, 32'h2000);
        pulse_start();
        chk("w4_busy", bus.busy, 1);
        wait_done("w4", 200, cyc_n);
        chk("w4_latency", cyc_n, 4 * (2 + 2 + 1) + 7 + 1 + 2 + 1);
        chk("w4_rd_cnt", n_rd_hs, 8);
        for (int i = 0; i < 8 && i < rd_addr_q.size(); i++) begin
            chk($sformatf("w4_rd_addr%0d", i), rd_addr_q[i],
                ((i % 2) ? 32'h1000 : 32'h0) + 32'(i / 2) * 32'd16);
            chk($sformatf("w4_rd_sel%0d", i), rd_sel_q[i], i % 2);
        end
        chk("w4_pe_step", n_pe_step, 4);
        chk("w4_pe_clear", n_pe_clear, 1);
        chk("w4_wr_cnt", n_wr_hs, 1);
        chk("w4_wr_addr", wr_addr_last, 32'h2000);
        chk("w4_err_busy", {bus.err, bus.busy}, 2'b00);
        cyc();
        chk("w4_sticky", {bus.busy, bus.done}, 2'b01);

        // W=16 with random ready stalls
        do_reset();
        stall_en = 1'b1;
        cfg(8'd16, 32'h4000, 32'h8000, 32'hC000);
        pulse_start();
        wait_done("w16", 3000, cyc_n);
        stall_en = 1'b0;
        chk("w16_rd_cnt", n_rd_hs, 32);
        chk("w16_pe_step", n_pe_step, 16);
        chk("w16_wr_cnt", n_wr_hs, 1);
        chk("w16_wr_addr", wr_addr_last, 32'hC000);
        chk("w16_stall_stable", stall_bad, 0);
        chk("w16_err", bus.err, 0);
        if (rd_addr_q.size() == 32) begin
            chk("w16_last_a", rd_addr_q[30], 32'h40F0);
            chk("w16_last_b", rd_addr_q[31], 32'h80F0);
        end else begin
            chk("w16_addr_log", rd_addr_q.size(), 32);
        end

        // W=0 is rejected straight to DONE
        do_reset();
        cfg(8'd0, 32'h0, 32'h1000, 32'h2000);
        pulse_start();
        wait_done("w0", 10, cyc_n);
        chk("w0_fast", cyc_n <= 2, 1);
        chk("w0_err", bus.err, 1);
        cyc();
        chk("w0_cmds", n_rd_hs + n_wr_vld + n_pe_step, 0);
        chk("w0_pe_clear", n_pe_clear, 1);
        chk("w0_idle", {bus.busy, bus.done, bus.err}, 3'b011);

        // rd_err on the third rd_done abandons the job
        do_reset();
        err_idx = 3;
        cfg(8'd8, 32'h100, 32'h200, 32'h300);
        pulse_start();
        wait_done("rderr", 300, cyc_n);
        err_idx = 0;
        chk("rderr_err", bus.err, 1);
        chk("rderr_no_wr", n_wr_vld, 0);
        chk("rderr_pe_step", n_pe_step, 1);
        chk("rderr_rd_cnt", n_rd_hs, 4);

        // start during a job is ignored
        do_reset();
        cfg(8'd4, 32'h0, 32'h1000, 32'h2000);
        pulse_start();
        wait_pe("restart", 2);
        cfg(8'd2, 32'h5000, 32'h6000, 32'h9000);
        pulse_start();
        wait_done("restart", 200, cyc_n);
        chk("restart_rd_cnt", n_rd_hs, 8);
        if (rd_addr_q.size() == 8) begin
            chk("restart_a2", rd_addr_q[4], 32'h20);
            chk("restart_b3", rd_addr_q[7], 32'h1030);
        end
        chk("restart_pe_step", n_pe_step, 4);
        chk("restart_wr_addr", wr_addr_last, 32'h2000);
        chk("restart_pe_clear", n_pe_clear, 1);

        // reset mid-job
        do_reset();
        cfg(8'd4, 32'h0, 32'h1000, 32'h2000);
        pulse_start();
        wait_pe("midrst", 2);
        chk("midrst_busy_before", bus.busy, 1);
        rst = 1'b1;
        cyc();
        chk("midrst_flags", {bus.busy, bus.done, bus.err, bus.rd_cmd_valid, bus.rd_cmd_sel,
                             bus.pe_clear, bus.pe_step, bus.wr_cmd_valid}, 8'h00);
        chk("midrst_addrs", {bus.rd_cmd_addr, bus.wr_cmd_addr}, 64'h0);
        rst = 1'b0;

        // address wrap and write error
        do_reset();
        wr_err_en = 1'b1;
        cfg(8'd2, 32'hFFFF_FFF0, 32'h1000, 32'h2000);
        pulse_start();
        wait_done("wrap", 100, cyc_n);
        wr_err_en = 1'b0;
        if (rd_addr_q.size() == 4) begin
            chk("wrap_a0", rd_addr_q[0], 32'hFFFF_FFF0);
            chk("wrap_a1", rd_addr_q[2], 32'h0000_0000);
        end else begin
            chk("wrap_addr_log", rd_addr_q.size(), 4);
        end
        chk("wrap_wr_err", bus.err, 1);
        chk("wrap_wr_cnt", n_wr_hs, 1);
        chk("wrap_pe_step", n_pe_step, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
